monopulse_integrator: RTL and testbench

Downstream stage of the monopulse ratio divider. It consumes the unsigned |error|/|reference| fixed-point quotient and restores the sign of the error/reference pair, which the divider discards. It saturates the result to a signed Q format and averages 2^LOG2_AVG consecutive samples into one angle-error estimate for the tracking loop. The sign of each division is captured when the division is launched and held in a small FIFO until that division's result returns.

---
 rtl/monopulse_integrator.sv | 184 ++++++++++++++++++
 tb/tb_monopulse_integrator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/monopulse_integrator.sv
// Monopulse angle-error integrator: restores the error/reference sign that the ratio divider
// drops, saturates the quotient to a signed Q word and averages 2^LOG2_AVG results per window.
module monopulse_integrator #(
    parameter int unsigned DATA_SIZE  = 64,
    parameter int unsigned OUT_SIZE   = 32,
    parameter int unsigned FRAC_OUT   = 16,
    parameter int unsigned LOG2_AVG   = 2,
    parameter int unsigned SIGN_DEPTH = 32
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [DATA_SIZE-1:0]          i_reference,
    input  logic [DATA_SIZE-1:0]          i_error,
    input  logic [2*DATA_SIZE-1:0]        i_result,
    input  logic                          i_valid,
    input  logic                          i_clear,
    output logic [OUT_SIZE-1:0]           o_angle,
    output logic                          o_valid,
    output logic                          o_error,
    output logic [$clog2(SIGN_DEPTH):0]   o_fill
);

    localparam int unsigned PTR_W    = $clog2(SIGN_DEPTH);
    localparam int unsigned INT_BITS = OUT_SIZE - FRAC_OUT - 1;
    localparam int unsigned MAG_W    = OUT_SIZE - 1;
    localparam int unsigned ACC_W    = OUT_SIZE + LOG2_AVG;
    localparam int unsigned CNT_W    = (LOG2_AVG > 0) ? LOG2_AVG : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(SIGN_DEPTH);

    typedef enum logic [0:0] {StFill, StEmit} state_t;

    // ------------------------------------------------------------------
    // Sign FIFO: one {neg, zero} entry per launched division
    // ------------------------------------------------------------------
    logic [1:0]       sign_mem [SIGN_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fill;
    logic             launch_neg;
    logic             launch_zero;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             pop_ok;
    logic             fifo_fault;
    logic             head_neg;
    logic             head_zero;

    // Launch sign decode and FIFO handshake; a pop frees the slot a same-cycle push needs
    always_comb begin
        launch_zero = (i_reference == '0);
        launch_neg  = launch_zero ? i_error[DATA_SIZE-1]
                                  : (i_error[DATA_SIZE-1] ^ i_reference[DATA_SIZE-1]);
        fifo_full   = (fill == FILL_FULL);
        fifo_empty  = (fill == '0);
        pop_ok      = i_valid && !fifo_empty;
        push_ok     = i_start && (!fifo_full || pop_ok);
        fifo_fault  = (i_start && !push_ok) || (i_valid && fifo_empty);
        {head_neg, head_zero} = sign_mem[rd_ptr];
    end

    // Sign storage; contents are don't-care until written, so no reset
    always_ff @(posedge i_clock) begin
        if (push_ok) begin
            sign_mem[wr_ptr] <= {launch_neg, launch_zero};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   fill <= fill + (PTR_W + 1)'(1);
                2'b01:   fill <= fill - (PTR_W + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    assign o_fill = fill;

    // ------------------------------------------------------------------
    // Conversion of the unsigned quotient to a signed saturated word
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] quotient;
    logic [DATA_SIZE-1:0] fraction;
    logic                 q_over;
    logic [MAG_W-1:0]     mag;
    logic [OUT_SIZE-1:0]  mag_ext;
    logic [OUT_SIZE-1:0]  conv_value;
    logic                 unused_frac;

    // Truncate to Q(INT_BITS).FRAC_OUT, clamp to full scale, then apply the stored sign
    always_comb begin
        quotient    = i_result[2*DATA_SIZE-1:DATA_SIZE];
        fraction    = i_result[DATA_SIZE-1:0];
        q_over      = |quotient[DATA_SIZE-1:INT_BITS];
        mag         = (q_over || head_zero) ? '1
                    : {quotient[INT_BITS-1:0], fraction[DATA_SIZE-1 -: FRAC_OUT]};
        mag_ext     = {1'b0, mag};
        // Symmetric range: negating a positive magnitude never yields the most negative code
        conv_value  = head_neg ? (~mag_ext + OUT_SIZE'(1)) : mag_ext;
        unused_frac = ^fraction[DATA_SIZE-FRAC_OUT-1:0];
    end

    // ------------------------------------------------------------------
    // Stage S1 and sticky fault flag
    // ------------------------------------------------------------------
    logic                       s1_valid;
    logic signed [OUT_SIZE-1:0] s1_value;

    // Register converted samples; underflowed returns never reach S1
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            s1_valid <= 1'b0;
            s1_value <= '0;
            o_error  <= 1'b0;
        end else begin
            s1_valid <= pop_ok && !i_clear;
            if (pop_ok) s1_value <= $signed(conv_value);
            if (i_clear)         o_error <= 1'b0;
            else if (fifo_fault) o_error <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Window accumulator and output FSM
    // ------------------------------------------------------------------
    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] s1_ext;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic                    win_done;

    // Running sum including the sample currently in S1
    always_comb begin
        s1_ext   = ACC_W'(s1_value);
        sum      = acc + s1_ext;
        win_done = s1_valid && (cnt == CNT_LAST);
    end

    // Accumulate samples; emit floor(sum / 2^LOG2_AVG) and restart on the last one
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= StFill;
            acc     <= '0;
            cnt     <= '0;
            o_angle <= '0;
            o_valid <= 1'b0;
        end else if (i_clear) begin
            state   <= StFill;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (state == StEmit) state <= StFill;
            // A sample arriving during StEmit opens the new window (acc/cnt already zero).
            // Only a one-sample window can complete there, which re-enters StEmit.
            if (win_done) begin
                // Upper slice of the sum is the arithmetic right shift (floor)
                o_angle <= sum[ACC_W-1:LOG2_AVG];
                o_valid <= 1'b1;
                acc     <= '0;
                cnt     <= '0;
                state   <= StEmit;
            end else if (s1_valid) begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_monopulse_integrator.sv
// Scoreboard bench for monopulse_integrator (LOG2_AVG = 2, four samples per window).
module tb_monopulse_integrator;

    localparam int DS = 64;
    localparam int OS = 32;

    localparam logic [127:0] R_ZERO = 128'd0;
    localparam logic [127:0] R_1_0  = {64'd1, 64'd0};
    localparam logic [127:0] R_0_75 = {64'd0, 64'hC000_0000_0000_0000};
    localparam logic [127:0] R_0_5  = {64'd0, 64'h8000_0000_0000_0000};
    localparam logic [127:0] R_0_25 = {64'd0, 64'h4000_0000_0000_0000};
    localparam logic [127:0] R_SAT  = {64'd40000, 64'd0};
    // One output LSB plus fraction bits below it that must be truncated away
    localparam logic [127:0] R_LSB  = {64'd0, 64'h0001_FFFF_FFFF_FFFF};

    logic            clk = 1'b0;
    logic            i_reset;
    logic            i_start;
    logic [DS-1:0]   i_reference;
    logic [DS-1:0]   i_error;
    logic [2*DS-1:0] i_result;
    logic            i_valid;
    logic            i_clear;
    logic [OS-1:0]   o_angle;
    logic            o_valid;
    logic            o_error;
    logic [5:0]      o_fill;

    typedef struct packed {
        logic [31:0] angle;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    monopulse_integrator #(
        .DATA_SIZE  (64),
        .OUT_SIZE   (32),
        .FRAC_OUT   (16),
        .LOG2_AVG   (2),
        .SIGN_DEPTH (32)
    ) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_reference (i_reference),
        .i_error     (i_error),
        .i_result    (i_result),
        .i_valid     (i_valid),
        .i_clear     (i_clear),
        .o_angle     (o_angle),
        .o_valid     (o_valid),
        .o_error     (o_error),
        .o_fill      (o_fill)
    );

    // Monitor: every o_valid pulse must match the next expected window, value and cycle
    always @(negedge clk) begin
        exp_t e;
        if (o_valid) begin
            n_tests = n_tests + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL window_unexpected: o_valid at cycle %0d angle 0x%08h, none required",
                         cyc, o_angle);
            end else begin
                e = sb_q.pop_front();
                if (o_angle !== e.angle || cyc != e.cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL window: got 0x%08h at cycle %0d, required 0x%08h at cycle %0d",
                             o_angle, cyc, e.angle, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one division, return its result next cycle; on the window's last sample
    // queue the expected angle two cycles after the i_valid cycle.
    task automatic div(input logic [63:0] e, input logic [63:0] r, input logic [127:0] res,
                       input bit last, input logic [31:0] exp_angle);
        exp_t x;
        i_start     = 1'b1;
        i_error     = e;
        i_reference = r;
        step();
        i_start  = 1'b0;
        i_valid  = 1'b1;
        i_result = res;
        if (last) begin
            x.angle = exp_angle;
            x.cyc   = cyc + 2;
            sb_q.push_back(x);
        end
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        exp_t x;
        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_reference = '0;
        i_error     = '0;
        i_result    = '0;
        i_valid     = 1'b0;
        i_clear     = 1'b0;
        #1;
        check("reset_angle", o_angle, 32'h0);
        check("reset_valid", {31'd0, o_valid}, 32'h0);
        check("reset_error", {31'd0, o_error}, 32'h0);
        check("reset_fill", {26'd0, o_fill}, 32'h0);
        step();
        step();
        i_reset = 1'b1;
        step();

        // Sign restore: 3/-4 -> -0.75, -3/-4 -> +0.75
        for (int i = 0; i < 4; i++) div(64'd3, -64'sd4, R_0_75, i == 3, 32'hFFFF_4000);
        for (int i = 0; i < 4; i++) div(-64'sd3, -64'sd4, R_0_75, i == 3, 32'h0000_C000);

        // Averaging: 1.0 + 0.5 - 0.25 + 0.75 = 2.0, /4 = 0.5
        div(64'd5, 64'd5, R_1_0, 1'b0, 32'h0);
        div(64'd1, 64'd2, R_0_5, 1'b0, 32'h0);
        div(-64'sd1, 64'd4, R_0_25, 1'b0, 32'h0);
        div(64'd3, 64'd4, R_0_75, 1'b1, 32'h0000_8000);

        // Quotient overflow saturates; divide-by-zero saturates with the error sign
        for (int i = 0; i < 4; i++) div(64'd40000, 64'd1, R_SAT, i == 3, 32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) div(-64'sd5, 64'd0, R_0_5, i == 3, 32'h8000_0001);

        // Rounding toward -inf: 0 + 0 + 0 - 1 LSB -> -1/4 floors to -1
        for (int i = 0; i < 3; i++) div(64'd0, 64'd1, R_ZERO, 1'b0, 32'h0);
        div(-64'sd1, 64'd1, R_LSB, 1'b1, 32'hFFFF_FFFF);

        // Streaming: 16 launches, then 16 back-to-back returns of -1.0
        for (int i = 0; i < 16; i++) begin
            i_start     = 1'b1;
            i_error     = -64'sd1;
            i_reference = 64'd1;
            step();
        end
        i_start = 1'b0;
        check("fill_16", {26'd0, o_fill}, 32'd16);
        for (int i = 0; i < 16; i++) begin
            i_valid  = 1'b1;
            i_result = R_1_0;
            if (i % 4 == 3) begin
                x.angle = 32'hFFFF_0000;
                x.cyc   = cyc + 2;
                sb_q.push_back(x);
            end
            step();
        end
        i_valid = 1'b0;
        repeat (4) step();
        check("angle_hold", o_angle, 32'hFFFF_0000);
        check("fill_drained", {26'd0, o_fill}, 32'd0);

        // FIFO full, overflow, and simultaneous push/pop at full
        for (int i = 0; i < 32; i++) begin
            i_start     = 1'b1;
            i_error     = 64'd1;
            i_reference = 64'd1;
            step();
        end
        i_start = 1'b0;
        check("fill_32", {26'd0, o_fill}, 32'd32);
        check("no_error_at_full", {31'd0, o_error}, 32'h0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("overflow_error", {31'd0, o_error}, 32'h1);
        check("overflow_fill", {26'd0, o_fill}, 32'd32);
        i_start  = 1'b1;
        i_valid  = 1'b1;
        i_result = R_0_5;
        step();
        i_start = 1'b0;
        i_valid = 1'b0;
        check("push_pop_full_fill", {26'd0, o_fill}, 32'd32);

        // Asynchronous reset mid-window, checked well before the next clock edge
        i_reset = 1'b0;
        #1;
        check("async_angle", o_angle, 32'h0);
        check("async_valid", {31'd0, o_valid}, 32'h0);
        check("async_error", {31'd0, o_error}, 32'h0);
        check("async_fill", {26'd0, o_fill}, 32'h0);
        step();
        i_reset = 1'b1;
        step();

        // Underflow: return with empty FIFO is dropped and flagged
        i_valid  = 1'b1;
        i_result = R_1_0;
        step();
        i_valid = 1'b0;
        check("underflow_error", {31'd0, o_error}, 32'h1);
        check("underflow_fill", {26'd0, o_fill}, 32'h0);
        // Window must consist of exactly these four samples
        for (int i = 0; i < 4; i++) div(64'd1, 64'd4, R_0_25, i == 3, 32'h0000_4000);

        // Clear: two partial samples are discarded, o_error cleared
        div(64'd1, 64'd1, R_1_0, 1'b0, 32'h0);
        div(64'd1, 64'd1, R_1_0, 1'b0, 32'h0);
        step();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("clear_error", {31'd0, o_error}, 32'h0);
        for (int i = 0; i < 4; i++) div(64'd1, 64'd2, R_0_5, i == 3, 32'h0000_8000);

        repeat (6) step();
        n_tests = n_tests + 1;
        if (sb_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL windows_missing: got %0d outstanding, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
